// File: rtl/bottling_pkg.sv
// Shared state encoding and default build constants for the fill-and-cork station.
package bottling_pkg;

  localparam int unsigned CORK_CAP_D     = 15;
  localparam int unsigned CORK_LOW_D     = 5;
  localparam int unsigned REFILL_MAX_D   = 3;
  localparam int unsigned SEAL_CYCLES_D  = 4;
  localparam int unsigned FILL_TIMEOUT_D = 1000;
  localparam int unsigned DOZEN_MAX_D    = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONVEY = 3'd1,
    S_FILL   = 3'd2,
    S_SEAL   = 3'd3,
    S_CLEAR  = 3'd4,
    S_REFILL = 3'd5,
    S_ALARM  = 3'd6
  } state_e;

endpackage

// File: rtl/bottle_tally.sv
// Production tally: mod-12 bottle counter feeding a saturating dozen counter.
module bottle_tally
  import bottling_pkg::*;
#(
  parameter int unsigned DOZEN_MAX = DOZEN_MAX_D
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  output logic [3:0] bottles,
  output logic [2:0] dozens
);

  localparam logic [2:0] DZ_MAX = 3'(DOZEN_MAX);

  logic [3:0] bottles_q, bottles_d;
  logic [2:0] dozens_q, dozens_d;

  always_comb begin
    bottles_d = bottles_q;
    dozens_d  = dozens_q;
    if (inc) begin
      if (bottles_q == 4'd11) begin
        bottles_d = '0;
        if (dozens_q < DZ_MAX) dozens_d = dozens_q + 3'd1;
      end else begin
        bottles_d = bottles_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bottles_q <= '0;
      dozens_q  <= '0;
    end else begin
      bottles_q <= bottles_d;
      dozens_q  <= dozens_d;
    end
  end

  assign bottles = bottles_q;
  assign dozens  = dozens_q;

endmodule

// File: rtl/bottling_sequencer.sv
// Fill-and-cork station controller: one Moore FSM sequencing conveyor, valve,
// sealer and cork dispenser, plus the cork/refill inventory and fill timeout.
module bottling_sequencer
  import bottling_pkg::*;
#(
  parameter int unsigned CORK_CAP     = CORK_CAP_D,
  parameter int unsigned CORK_LOW     = CORK_LOW_D,
  parameter int unsigned REFILL_MAX   = REFILL_MAX_D,
  parameter int unsigned SEAL_CYCLES  = SEAL_CYCLES_D,
  parameter int unsigned FILL_TIMEOUT = FILL_TIMEOUT_D,
  parameter int unsigned DOZEN_MAX    = DOZEN_MAX_D
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ST,
  input  logic       PG,
  input  logic       CH,
  output logic       motor,
  output logic       EV,
  output logic       VE,
  output logic       disp,
  output logic       alarm,
  output logic [2:0] state,
  output logic [3:0] corks,
  output logic [1:0] refills,
  output logic [3:0] bottles,
  output logic [2:0] dozens
);

  localparam int unsigned TW = $clog2(FILL_TIMEOUT);
  localparam int unsigned SW = $clog2(SEAL_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SEAL_CYCLES - 1);
  localparam logic [3:0] CAP_C = 4'(CORK_CAP);
  localparam logic [3:0] LOW_C = 4'(CORK_LOW);
  localparam logic [1:0] RMAX_C = 2'(REFILL_MAX);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   seal_q, seal_d;
  logic [3:0]      corks_q, corks_d;
  logic [1:0]      refills_q, refills_d;
  logic            fill_expired, seal_done, tally_inc;

  assign fill_expired = (timer_q == T_LAST);
  assign seal_done    = (seal_q == S_LAST);
  assign tally_inc    = (state_q == S_SEAL) && seal_done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (ST) state_d = S_CONVEY;
      S_CONVEY: begin
        if (!ST)                                    state_d = S_IDLE;
        else if (corks_q == '0)                     state_d = S_ALARM;
        else if (corks_q <= LOW_C && refills_q != '0) state_d = S_REFILL;
        else if (PG)                                state_d = S_FILL;
      end
      S_REFILL: state_d = S_CONVEY;
      // CH beats a simultaneous timeout.
      S_FILL: begin
        if (CH)                state_d = S_SEAL;
        else if (fill_expired) state_d = S_ALARM;
      end
      S_SEAL:   if (seal_done) state_d = S_CLEAR;
      S_CLEAR:  if (!PG) state_d = S_CONVEY;
      S_ALARM:  if (!ST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    motor = 1'b0;
    EV    = 1'b0;
    VE    = 1'b0;
    disp  = 1'b0;
    alarm = 1'b0;
    unique case (state_q)
      S_CONVEY, S_CLEAR: motor = 1'b1;
      S_FILL:            EV    = 1'b1;
      S_SEAL:            VE    = 1'b1;
      S_REFILL:          disp  = 1'b1;
      S_ALARM:           alarm = 1'b1;
      default: ;
    endcase
  end

  // Both counters idle at zero outside their state, so entry always starts from zero.
  always_comb begin
    timer_d   = (state_q == S_FILL) ? timer_q + 1'b1 : '0;
    seal_d    = (state_q == S_SEAL) ? seal_q + 1'b1 : '0;
    corks_d   = corks_q;
    refills_d = refills_q;
    if (state_q == S_REFILL) begin
      corks_d   = CAP_C;
      refills_d = refills_q - 2'd1;
    end else if (tally_inc) begin
      corks_d = corks_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer_q   <= '0;
      seal_q    <= '0;
      corks_q   <= CAP_C;
      refills_q <= RMAX_C;
    end else begin
      timer_q   <= timer_d;
      seal_q    <= seal_d;
      corks_q   <= corks_d;
      refills_q <= refills_d;
    end
  end

  bottle_tally #(
    .DOZEN_MAX(DOZEN_MAX)
  ) u_tally (
    .CLK    (CLK),
    .RST    (RST),
    .inc    (tally_inc),
    .bottles(bottles),
    .dozens (dozens)
  );

  assign state   = state_q;
  assign corks   = corks_q;
  assign refills = refills_q;

endmodule
